// File: rtl/memory_stage.sv
// memory_stage: RISC-V MEM stage driving a req/ready data-memory port with lane steering and load extension.
// Optional MEM_MISALIGN_CHECK_EN: misaligned accesses are flagged and not issued instead of being force-aligned.
module memory_stage #(
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  MEM_valid_i,
   input  logic                  MEM_MemRead_i,
   input  logic                  MEM_MemWrite_i,
   input  logic [2:0]            MEM_funct3_i,
   input  logic [DATA_WIDTH-1:0] MEM_alu_result_i,
   input  logic [DATA_WIDTH-1:0] MEM_wr_data_i,
   output logic                  dmem_req_o,
   output logic                  dmem_we_o,
   output logic [DATA_WIDTH-1:0] dmem_addr_o,
   output logic [DATA_WIDTH-1:0] dmem_wdata_o,
   output logic [3:0]            dmem_be_o,
   input  logic                  dmem_ready_i,
   input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
   output logic [DATA_WIDTH-1:0] MEM_rd_data_o,
   output logic                  MEM_stall_o,
   output logic                  MEM_misaligned_o,
   output logic                  MEM_bus_err_o
);
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
   state_t                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  req_q, req_d, we_q, we_d, err_q, err_d, uns_q, uns_d, load_q, load_d;
   logic [DATA_WIDTH-1:0] addr_q, addr_d, wdata_q, wdata_d, rd_q, rd_d, ext;
   logic [3:0]            be_q, be_d;
   logic [1:0]            sz_q, sz_d, off_q, off_d, sz, off;
   logic                  access, issue;
   logic [7:0]            ld_b;
   logic [15:0]           ld_h;
   always_comb begin
      access = MEM_valid_i & (MEM_MemRead_i | MEM_MemWrite_i);
      sz     = MEM_funct3_i[1:0] == 2'b00 ? 2'd0 : MEM_funct3_i[1:0] == 2'b01 ? 2'd1 : 2'd2;
      // Offset is forced to size alignment; only matters when misaligned accesses are issued.
      off    = sz == 2'd0 ? MEM_alu_result_i[1:0] : sz == 2'd1 ? {MEM_alu_result_i[1], 1'b0} : 2'b00;
`ifdef MEM_MISALIGN_CHECK_EN
      MEM_misaligned_o = access & (sz == 2'd1 ? MEM_alu_result_i[0] : sz == 2'd2 ? |MEM_alu_result_i[1:0] : 1'b0);
      issue  = access & ~MEM_misaligned_o;
`else
      MEM_misaligned_o = 1'b0;
      issue  = access;
`endif
      ld_b   = dmem_rdata_i[{off_q, 3'b000} +: 8];
      ld_h   = dmem_rdata_i[{off_q[1], 4'b0000} +: 16];
      ext    = sz_q == 2'd0 ? {{24{~uns_q & ld_b[7]}}, ld_b} :
               sz_q == 2'd1 ? {{16{~uns_q & ld_h[15]}}, ld_h} : dmem_rdata_i;
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      rd_d    = rd_q;
      err_d   = 1'b0;
      sz_d    = sz_q;
      off_d   = off_q;
      uns_d   = uns_q;
      load_d  = load_q;
      if (state_q == IDLE && issue) begin
         state_d = BUSY;
         cnt_d   = '0;
         req_d   = 1'b1;
         we_d    = MEM_MemWrite_i;
         addr_d  = {MEM_alu_result_i[DATA_WIDTH-1:2], 2'b00};
         wdata_d = sz == 2'd0 ? {4{MEM_wr_data_i[7:0]}} : sz == 2'd1 ? {2{MEM_wr_data_i[15:0]}} : MEM_wr_data_i;
         be_d    = sz == 2'd0 ? 4'b0001 << off : sz == 2'd1 ? 4'b0011 << off : 4'b1111;
         sz_d    = sz;
         off_d   = off;
         uns_d   = MEM_funct3_i[2];
         load_d  = ~MEM_MemWrite_i;
      end else if (state_q == BUSY) begin
         cnt_d = cnt_q + CW'(1);
         if (dmem_ready_i) begin
            state_d = DONE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            rd_d    = load_q ? ext : rd_q;
         end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
            state_d = DONE;
            req_d   = 1'b0;
            we_d    = 1'b0;
            rd_d    = '0;
            err_d   = 1'b1;
         end
      end else if (state_q == DONE) begin
         state_d = IDLE;
      end
      MEM_stall_o = ~rst & ((state_q == IDLE & issue) | state_q == BUSY);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         be_q    <= '0;
         rd_q    <= '0;
         err_q   <= 1'b0;
         sz_q    <= '0;
         off_q   <= '0;
         uns_q   <= 1'b0;
         load_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         rd_q    <= rd_d;
         err_q   <= err_d;
         sz_q    <= sz_d;
         off_q   <= off_d;
         uns_q   <= uns_d;
         load_q  <= load_d;
      end
   end
   assign dmem_req_o    = req_q;
   assign dmem_we_o     = we_q;
   assign dmem_addr_o   = addr_q;
   assign dmem_wdata_o  = wdata_q;
   assign dmem_be_o     = be_q;
   assign MEM_rd_data_o = rd_q;
   assign MEM_bus_err_o = err_q;
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized self-checking bench for memory_stage against a byte-arithmetic reference model.
// A second instance with TIMEOUT_CYCLES=4 covers the timeout paths.
module tb_memory_stage;
   logic clk = 1'b0, rst = 1'b1;
   logic valid = 0, mrd = 0, mwr = 0, ready = 0;
   logic [2:0] f3 = 0;
   logic [31:0] alu = 0, wd = 0, rdata = 0;
   logic a_req, a_we, a_stall, a_mis, a_err, t_req, t_we, t_stall, t_mis, t_err;
   logic [31:0] a_addr, a_wdata, a_rd, t_addr, t_wdata, t_rd;
   logic [3:0] a_be, t_be;
   logic use_to = 0;
   logic o_req, o_we, o_stall, o_mis, o_err;
   logic [31:0] o_addr, o_wdata, o_rd;
   logic [3:0] o_be;
   int n_chk = 0, n_fail = 0;
   always #5 clk = ~clk;
   memory_stage dut (.clk(clk), .rst(rst), .MEM_valid_i(valid), .MEM_MemRead_i(mrd), .MEM_MemWrite_i(mwr),
      .MEM_funct3_i(f3), .MEM_alu_result_i(alu), .MEM_wr_data_i(wd), .dmem_req_o(a_req), .dmem_we_o(a_we),
      .dmem_addr_o(a_addr), .dmem_wdata_o(a_wdata), .dmem_be_o(a_be), .dmem_ready_i(ready), .dmem_rdata_i(rdata),
      .MEM_rd_data_o(a_rd), .MEM_stall_o(a_stall), .MEM_misaligned_o(a_mis), .MEM_bus_err_o(a_err));
   memory_stage #(.TIMEOUT_CYCLES(4)) dut_to (.clk(clk), .rst(rst), .MEM_valid_i(valid), .MEM_MemRead_i(mrd),
      .MEM_MemWrite_i(mwr), .MEM_funct3_i(f3), .MEM_alu_result_i(alu), .MEM_wr_data_i(wd), .dmem_req_o(t_req),
      .dmem_we_o(t_we), .dmem_addr_o(t_addr), .dmem_wdata_o(t_wdata), .dmem_be_o(t_be), .dmem_ready_i(ready),
      .dmem_rdata_i(rdata), .MEM_rd_data_o(t_rd), .MEM_stall_o(t_stall), .MEM_misaligned_o(t_mis), .MEM_bus_err_o(t_err));
   assign o_req   = use_to ? t_req : a_req;
   assign o_we    = use_to ? t_we : a_we;
   assign o_stall = use_to ? t_stall : a_stall;
   assign o_mis   = use_to ? t_mis : a_mis;
   assign o_err   = use_to ? t_err : a_err;
   assign o_addr  = use_to ? t_addr : a_addr;
   assign o_wdata = use_to ? t_wdata : a_wdata;
   assign o_rd    = use_to ? t_rd : a_rd;
   assign o_be    = use_to ? t_be : a_be;
   // Reference model: access size in bytes, then plain arithmetic on byte positions.
   function automatic int m_n(input logic [2:0] f);
      case (f)
         3'd0, 3'd4: return 1;
         3'd1, 3'd5: return 2;
         default:    return 4;
      endcase
   endfunction
   function automatic logic [31:0] m_align(input logic [31:0] a, input logic [2:0] f);
      return a - (a % m_n(f));
   endfunction
   function automatic logic m_misal(input logic [31:0] a, input logic [2:0] f);
      return (a % m_n(f)) != 0;
   endfunction
   function automatic logic [3:0] m_be(input logic [31:0] a, input logic [2:0] f);
      int n = m_n(f);
      int p = m_align(a, f) % 4;
      return 4'(((1 << n) - 1) << p);
   endfunction
   function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [2:0] f);
      int n = m_n(f);
      return n == 1 ? (d & 32'hFF) * 32'h01010101 : n == 2 ? (d & 32'hFFFF) * 32'h00010001 : d;
   endfunction
   function automatic logic [31:0] m_load(input logic [31:0] r, input logic [31:0] a, input logic [2:0] f);
      int n = m_n(f);
      longint v = (longint'(r) >> (8 * (m_align(a, f) % 4))) & ((64'd1 << (8 * n)) - 1);
      if (n < 4 && f < 3'd4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
      return 32'(v);
   endfunction
   task automatic do_reset();
      rst = 1; valid = 0; ready = 0;
      repeat (2) @(negedge clk);
      rst = 0;
   endtask
   // Drives one access and reports what the selected instance did; dly<0 means ready never comes.
   task automatic run_access(input logic r, input logic w, input logic [2:0] f, input logic [31:0] a,
         input logic [31:0] d, input logic [31:0] rv, input int dly, output int stalls, output int busy,
         output logic [31:0] ao, output logic [31:0] wo, output logic [3:0] beo, output logic weo,
         output logic stable, output int errs, output logic ok);
      stalls = 0; busy = 0; errs = 0; stable = 1; ok = 0; ao = 0; wo = 0; beo = 0; weo = 0;
      @(negedge clk);
      valid = 1; mrd = r; mwr = w; f3 = f; alu = a; wd = d; ready = 0;
      for (int c = 0; c < 400; c++) begin
         if (c > 0) begin
            @(negedge clk);
            ready = 0; valid = 0; alu = $urandom; wd = $urandom; f3 = 3'($urandom);
         end
         if (o_err) errs++;
         if (o_req) begin
            busy++;
            if (busy == 1) begin
               ao = o_addr; wo = o_wdata; beo = o_be; weo = o_we;
            end else if (ao !== o_addr || wo !== o_wdata || beo !== o_be || weo !== o_we) stable = 0;
            if (dly >= 0 && busy == dly + 1) begin
               ready = 1; rdata = rv;
            end
         end else rdata = $urandom;
         #1;
         if (o_stall) stalls++;
         else if (c > 0) begin
            ok = 1;
            break;
         end
      end
   endtask
   task automatic test_reset();
      rst = 1; valid = 1; mrd = 1; mwr = 0; f3 = 3'd2; alu = 32'h100;
      @(negedge clk); #1;
      n_chk++; if (a_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", a_stall); end
      n_chk++; if (a_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", a_req); end
      n_chk++; if ({a_we, a_addr, a_wdata, a_be, a_rd, a_err, a_mis} !== '0) begin n_fail++;
         $display("FAIL reset_outputs: got we=%b addr=%h wdata=%h be=%b rd=%h err=%b mis=%b expected all 0",
            a_we, a_addr, a_wdata, a_be, a_rd, a_err, a_mis); end
      valid = 0;
      do_reset();
   endtask
   task automatic test_lw();
      int s, b, e; logic [31:0] ao, wo; logic [3:0] be; logic we, st, ok;
      run_access(1, 0, 3'd2, 32'h100, 0, 32'hDEADBEEF, 0, s, b, ao, wo, be, we, st, e, ok);
      n_chk++; if (!ok || s != 2) begin n_fail++; $display("FAIL lw_stall: got %0d ok=%b expected 2", s, ok); end
      n_chk++; if (ao !== 32'h100 || be !== 4'hF || we !== 1'b0) begin n_fail++;
         $display("FAIL lw_req: got addr=%h be=%b we=%b expected 00000100 1111 0", ao, be, we); end
      n_chk++; if (a_rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_data: got %h expected deadbeef", a_rd); end
   endtask
   task automatic test_lb_lbu();
      int s, b, e; logic [31:0] ao, wo; logic [3:0] be; logic we, st, ok;
      run_access(1, 0, 3'd0, 32'h103, 0, 32'h80FF0000, 0, s, b, ao, wo, be, we, st, e, ok);
      n_chk++; if (a_rd !== 32'hFFFFFF80 || be !== 4'b1000) begin n_fail++;
         $display("FAIL lb_data: got %h be=%b expected ffffff80 1000", a_rd, be); end
      run_access(1, 0, 3'd4, 32'h103, 0, 32'h80FF0000, 1, s, b, ao, wo, be, we, st, e, ok);
      n_chk++; if (a_rd !== 32'h00000080 || s != 3) begin n_fail++;
         $display("FAIL lbu_data: got %h stalls=%0d expected 00000080 3", a_rd, s); end
   endtask
   task automatic test_sh();
      int s, b, e; logic [31:0] ao, wo, prev; logic [3:0] be; logic we, st, ok;
      prev = a_rd;
      run_access(0, 1, 3'd1, 32'h102, 32'h1234ABCD, 32'hFFFFFFFF, 0, s, b, ao, wo, be, we, st, e, ok);
      n_chk++; if (be !== 4'b1100 || wo !== 32'hABCDABCD || we !== 1'b1 || ao !== 32'h100) begin n_fail++;
         $display("FAIL sh_req: got be=%b wdata=%h we=%b addr=%h expected 1100 abcdabcd 1 00000100", be, wo, we, ao); end
      n_chk++; if (a_rd !== prev) begin n_fail++; $display("FAIL sh_rd_hold: got %h expected %h", a_rd, prev); end
   endtask
   task automatic test_delay_reset();
      int s, b, e; logic [31:0] ao, wo, prev; logic [3:0] be; logic we, st, ok;
      run_access(1, 0, 3'd2, 32'h200, 0, 32'h5A5A1234, 5, s, b, ao, wo, be, we, st, e, ok);
      n_chk++; if (s != 7 || !st || a_rd !== 32'h5A5A1234) begin n_fail++;
         $display("FAIL delay_lw: got stalls=%0d stable=%b rd=%h expected 7 1 5a5a1234", s, st, a_rd); end
      prev = a_rd;
      @(negedge clk);
      valid = 1; mrd = 1; mwr = 0; f3 = 3'd2; alu = 32'h300;
      @(negedge clk);
      valid = 0; alu = 32'h777;
      #1;
      n_chk++; if (a_req !== 1'b1) begin n_fail++; $display("FAIL rst_busy_req: got %b expected 1", a_req); end
      rst = 1; #1;
      n_chk++; if (a_req !== 1'b0 || a_stall !== 1'b0) begin n_fail++;
         $display("FAIL rst_mid_busy: got req=%b stall=%b expected 0 0", a_req, a_stall); end
      @(negedge clk); rst = 0;
      @(negedge clk); ready = 1; #1;
      n_chk++; if (a_req !== 1'b0 || a_stall !== 1'b0 || a_err !== 1'b0 || a_rd !== 32'h0) begin n_fail++;
         $display("FAIL after_rst: got req=%b stall=%b err=%b rd=%h expected 0 0 0 0", a_req, a_stall, a_err, a_rd); end
      ready = 0;
      run_access(1, 0, 3'd2, 32'h400, 0, 32'hCAFEF00D, 0, s, b, ao, wo, be, we, st, e, ok);
      n_chk++; if (s != 2 || a_rd !== 32'hCAFEF00D) begin n_fail++;
         $display("FAIL after_rst_lw: got stalls=%0d rd=%h expected 2 cafef00d", s, a_rd); end
   endtask
   task automatic test_timeout();
      int s, b, e; logic [31:0] ao, wo; logic [3:0] be; logic we, st, ok;
      do_reset();
      use_to = 1;
      run_access(1, 0, 3'd2, 32'h40, 0, 32'h12345678, 0, s, b, ao, wo, be, we, st, e, ok);
      n_chk++; if (t_rd !== 32'h12345678) begin n_fail++; $display("FAIL to_prime: got %h expected 12345678", t_rd); end
      run_access(1, 0, 3'd2, 32'h44, 0, 32'h0BADF00D, 3, s, b, ao, wo, be, we, st, e, ok);
      n_chk++; if (b != 4 || e != 0 || t_rd !== 32'h0BADF00D) begin n_fail++;
         $display("FAIL ready_at_limit: got busy=%0d errs=%0d rd=%h expected 4 0 0badf00d", b, e, t_rd); end
      run_access(1, 0, 3'd2, 32'h48, 0, 32'h0, -1, s, b, ao, wo, be, we, st, e, ok);
      n_chk++; if (!ok || b != 4 || s != 5 || e != 1 || t_rd !== 32'h0) begin n_fail++;
         $display("FAIL timeout: got ok=%b busy=%0d stalls=%0d errs=%0d rd=%h expected 1 4 5 1 0", ok, b, s, e, t_rd); end
      @(negedge clk); #1;
      n_chk++; if (t_err !== 1'b0 || t_stall !== 1'b0 || t_req !== 1'b0) begin n_fail++;
         $display("FAIL timeout_after: got err=%b stall=%b req=%b expected 0 0 0", t_err, t_stall, t_req); end
      use_to = 0;
      do_reset();
   endtask
   task automatic test_misalign();
      int s, b, e; logic [31:0] ao, wo; logic [3:0] be; logic we, st, ok;
`ifdef MEM_MISALIGN_CHECK_EN
      @(negedge clk);
      valid = 1; mrd = 1; mwr = 0; f3 = 3'd2; alu = 32'h102; #1;
      n_chk++; if (a_mis !== 1'b1 || a_stall !== 1'b0) begin n_fail++;
         $display("FAIL misalign_flag: got mis=%b stall=%b expected 1 0", a_mis, a_stall); end
      @(negedge clk); #1;
      n_chk++; if (a_req !== 1'b0 || a_stall !== 1'b0 || a_mis !== 1'b1) begin n_fail++;
         $display("FAIL misalign_noreq: got req=%b stall=%b mis=%b expected 0 0 1", a_req, a_stall, a_mis); end
      valid = 0; #1;
      n_chk++; if (a_mis !== 1'b0) begin n_fail++; $display("FAIL misalign_clear: got %b expected 0", a_mis); end
`else
      run_access(1, 0, 3'd2, 32'h102, 0, 32'h01020304, 0, s, b, ao, wo, be, we, st, e, ok);
      n_chk++; if (ao !== 32'h100 || be !== 4'hF || a_mis !== 1'b0 || a_rd !== 32'h01020304) begin n_fail++;
         $display("FAIL misalign_forced: got addr=%h be=%b mis=%b rd=%h expected 00000100 1111 0 01020304", ao, be, a_mis, a_rd); end
`endif
   endtask
   task automatic test_random();
      int s, b, e, dly, kind; logic [31:0] ao, wo, a, d, rv, exp_rd; logic [3:0] be; logic [2:0] f;
      logic we, st, ok, r, w;
      exp_rd = a_rd;
      for (int i = 0; i < 60; i++) begin
         kind = $urandom_range(0, 2);
         r = kind != 1; w = kind != 0;
         f = w ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
         a = $urandom; d = $urandom; rv = $urandom; dly = $urandom_range(0, 3);
`ifdef MEM_MISALIGN_CHECK_EN
         if (m_misal(a, f)) begin
            @(negedge clk);
            valid = 1; mrd = r; mwr = w; f3 = f; alu = a; #1;
            n_chk++; if (a_mis !== 1'b1 || a_stall !== 1'b0) begin n_fail++;
               $display("FAIL rnd_misal %0d: got mis=%b stall=%b expected 1 0", i, a_mis, a_stall); end
            @(negedge clk); valid = 0;
            continue;
         end
`endif
         run_access(r, w, f, a, d, rv, dly, s, b, ao, wo, be, we, st, e, ok);
         if (!w) exp_rd = m_load(rv, a, f);
         n_chk++; if (ao !== (a & ~32'h3) || be !== m_be(a, f) || wo !== m_wdata(d, f) || we !== w) begin n_fail++;
            $display("FAIL rnd_req %0d: got addr=%h be=%b wdata=%h we=%b expected %h %b %h %b",
               i, ao, be, wo, we, a & ~32'h3, m_be(a, f), m_wdata(d, f), w); end
         n_chk++; if (a_rd !== exp_rd || s != dly + 2 || !st) begin n_fail++;
            $display("FAIL rnd_done %0d: got rd=%h stalls=%0d stable=%b expected %h %0d 1", i, a_rd, s, st, exp_rd, dly + 2); end
      end
   endtask
   initial begin
      test_reset();
      test_lw();
      test_lb_lbu();
      test_sh();
      test_delay_reset();
      test_timeout();
      test_misalign();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
